// File: rtl/pmp_seq_check.sv
// Sequential PMP checker. It takes one physical-address check at a time and
// scans the PMP entries in priority order, one entry per cycle, through a
// single shared pmp_entry matcher. This file also holds the configuration and
// RISC-V type packages and the single-entry matcher that the checker uses.

package config_pkg;

   // Core configuration fields that the PMP logic reads.
   typedef struct packed {
      bit PMPNa4En;  // NA4 address matching is implemented
   } cva6_cfg_t;

   // Default configuration: every PMP address-matching mode is available.
   localparam cva6_cfg_t cva6_cfg_empty = '{PMPNa4En: 1'b1};

endpackage

package riscv;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_M = 2'b11
   } priv_lvl_t;

   // One-hot requested access: bit 0 = R, bit 1 = W, bit 2 = X.
   typedef enum logic [2:0] {
      ACCESS_NONE  = 3'b000,
      ACCESS_READ  = 3'b001,
      ACCESS_WRITE = 3'b010,
      ACCESS_EXEC  = 3'b100
   } pmp_access_t;

   typedef enum logic [1:0] {
      OFF   = 2'b00,
      TOR   = 2'b01,
      NA4   = 2'b10,
      NAPOT = 2'b11
   } pmp_addr_mode_t;

   // Permission bits laid out so that bit 0 = R, bit 1 = W, bit 2 = X.
   typedef struct packed {
      logic x;
      logic w;
      logic r;
   } pmpcfg_access_t;

   typedef struct packed {
      logic           locked;
      pmp_addr_mode_t addr_mode;
      pmpcfg_access_t access_type;
   } pmpcfg_t;

endpackage

// Single-entry PMP address matcher: does addr_i fall in the region described
// by one pmpaddr/pmpcfg pair (plus the previous pmpaddr as the TOR base)?
module pmp_entry #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
   parameter int unsigned           PLEN    = 56,
   parameter int unsigned           PMP_LEN = 54
) (
   input  logic [PLEN-1:0]        addr_i,
   input  logic [PMP_LEN-1:0]     conf_addr_i,
   input  logic [PMP_LEN-1:0]     conf_addr_prev_i,
   input  riscv::pmp_addr_mode_t  conf_addr_mode_i,
   output logic                   match_o
);

   // Compare width covers both the physical address and a pmpaddr scaled to bytes.
   localparam int unsigned CMP_W = (PLEN > PMP_LEN + 2) ? PLEN : PMP_LEN + 2;

   logic [CMP_W-1:0] addr_ext;   // byte address
   logic [CMP_W-1:0] tor_base;   // inclusive TOR lower bound, bytes
   logic [CMP_W-1:0] tor_top;    // exclusive TOR upper bound, bytes
   logic [CMP_W-3:0] addr_word;  // address in 4-byte granules
   logic [CMP_W-3:0] conf_word;  // pmpaddr in 4-byte granules
   logic [CMP_W-3:0] napot_mask; // granule bits ignored by a NAPOT region

   assign addr_ext  = CMP_W'(addr_i);
   assign tor_base  = CMP_W'({conf_addr_prev_i, 2'b00});
   assign tor_top   = CMP_W'({conf_addr_i, 2'b00});
   assign addr_word = addr_ext[CMP_W-1:2];
   assign conf_word = (CMP_W-2)'(conf_addr_i);

   // x ^ (x + 1) sets the trailing-ones run of pmpaddr plus the zero above it,
   // which is exactly the set of granule bits that vary inside the region.
   assign napot_mask = conf_word ^ (conf_word + (CMP_W-2)'(1));

   // Decide whether the address lies inside the region for the selected mode.
   always_comb begin
      // NOTE: the output gets a default before the case, so no latch is inferred.
      match_o = 1'b0;
      unique case (conf_addr_mode_i)
         riscv::OFF:   match_o = 1'b0;
         riscv::TOR:   match_o = (addr_ext >= tor_base) && (addr_ext < tor_top);
         riscv::NA4:   match_o = CVA6Cfg.PMPNa4En && (addr_word == conf_word);
         riscv::NAPOT: match_o = (addr_word & ~napot_mask) == (conf_word & ~napot_mask);
         default:      match_o = 1'b0;
      endcase
   end

endmodule

// Area-optimised PMP checker: one pmp_entry instance, one entry per cycle.
module pmp_seq_check #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg    = config_pkg::cva6_cfg_empty,
   parameter int unsigned           PLEN       = 56,
   parameter int unsigned           PMP_LEN    = 54,
   parameter int unsigned           NR_ENTRIES = 16,
   localparam int unsigned          IDX_W      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   flush_i,
   input  logic                                   req_valid_i,
   output logic                                   req_ready_o,
   input  logic [PLEN-1:0]                        addr_i,
   input  riscv::pmp_access_t                     access_type_i,
   input  riscv::priv_lvl_t                       priv_lvl_i,
   input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]     conf_addr_i,
   input  riscv::pmpcfg_t [NR_ENTRIES-1:0]        conf_i,
   output logic                                   resp_valid_o,
   input  logic                                   resp_ready_i,
   output logic                                   resp_allow_o,
   output logic                                   resp_hit_o,
   output logic [IDX_W-1:0]                       resp_entry_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      RESP
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    idx;

   // Request captured at acceptance; the live inputs may change afterwards.
   logic [PLEN-1:0]     req_addr;
   riscv::pmp_access_t  req_access;
   riscv::priv_lvl_t    req_priv;

   riscv::pmpcfg_t      cur_cfg;
   logic [PMP_LEN-1:0]  cur_addr;
   logic [PMP_LEN-1:0]  prev_addr;
   logic [2:0]          want;
   logic [2:0]          have;
   logic                match;
   logic                m_mode;
   logic                perm_ok;
   logic                entry_allow;
   logic                last_entry;

   assign req_ready_o = (state == IDLE);

   // Entry under scan; the configuration arrays are read live.
   assign cur_cfg  = conf_i[idx];
   assign cur_addr = conf_addr_i[idx];

   // Lower TOR bound: the previous pmpaddr, or zero for entry 0.
   always_comb begin
      prev_addr = '0;
      if (idx != '0) begin
         prev_addr = conf_addr_i[idx - IDX_W'(1)];
      end
   end

   pmp_entry #(
      .CVA6Cfg (CVA6Cfg),
      .PLEN    (PLEN),
      .PMP_LEN (PMP_LEN)
   ) i_pmp_entry (
      .addr_i           (req_addr),
      .conf_addr_i      (cur_addr),
      .conf_addr_prev_i (prev_addr),
      .conf_addr_mode_i (cur_cfg.addr_mode),
      .match_o          (match)
   );

   // Permission decision for the entry under scan. M-mode bypasses the
   // permission bits of an unlocked entry; a locked entry binds M-mode too.
   assign want        = req_access;
   assign have        = cur_cfg.access_type;
   assign perm_ok     = ((want & have) == want);
   assign m_mode      = (req_priv == riscv::PRIV_LVL_M);
   assign entry_allow = (m_mode && !cur_cfg.locked) || perm_ok;

   // The range check also guards against an index past the last entry, so a
   // scan always ends even if the configuration changes underneath it.
   assign last_entry = (idx >= LAST_IDX);

   // Scan FSM with registered response outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         idx          <= '0;
         req_addr     <= '0;
         req_access   <= riscv::ACCESS_NONE;
         req_priv     <= riscv::PRIV_LVL_U;
         resp_valid_o <= 1'b0;
         resp_allow_o <= 1'b0;
         resp_hit_o   <= 1'b0;
         resp_entry_o <= '0;
      end else if (flush_i) begin
         // NOTE: non-blocking assignments keep every register update in step
         // with the clock edge, independent of statement order.
         state        <= IDLE;
         idx          <= '0;
         resp_valid_o <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid_i) begin
                  req_addr   <= addr_i;
                  req_access <= access_type_i;
                  req_priv   <= priv_lvl_i;
                  idx        <= '0;
                  state      <= SCAN;
               end
            end

            SCAN: begin
               if (match) begin
                  // First match wins: lowest index has priority.
                  resp_hit_o   <= 1'b1;
                  resp_entry_o <= idx;
                  resp_allow_o <= entry_allow;
                  resp_valid_o <= 1'b1;
                  state        <= RESP;
               end else if (last_entry) begin
                  // No entry matched: only M-mode is allowed through.
                  resp_hit_o   <= 1'b0;
                  resp_entry_o <= '0;
                  resp_allow_o <= m_mode;
                  resp_valid_o <= 1'b1;
                  state        <= RESP;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end

            RESP: begin
               if (resp_ready_i) begin
                  resp_valid_o <= 1'b0;
                  state        <= IDLE;
               end
            end

            default: begin
               resp_valid_o <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pmp_seq_check.sv
// Self-checking bench for pmp_seq_check. A behavioural PMP model computes the
// expected hit/entry/allow and latency from region arithmetic; one monitor
// compares the DUT against it on every falling edge.

module tb_pmp_seq_check;

   localparam int unsigned PLEN    = 56;
   localparam int unsigned PMP_LEN = 54;
   localparam int unsigned NR      = 16;
   localparam int unsigned IW      = 4;
   localparam int          PERIOD  = 10;

   localparam logic [2:0] RD = 3'b001;
   localparam logic [2:0] WR = 3'b010;
   localparam logic [2:0] EX = 3'b100;
   localparam logic [1:0] PU = 2'b00;
   localparam logic [1:0] PS = 2'b01;
   localparam logic [1:0] PM = 2'b11;

   typedef struct packed {
      logic          hit;
      logic [IW-1:0] entry;
      logic          allow;
   } model_t;

   logic                            clk;
   logic                            rst_ni;
   logic                            flush;
   logic                            req_valid;
   logic                            req_ready_o;
   logic [PLEN-1:0]                 addr;
   riscv::pmp_access_t              access;
   riscv::priv_lvl_t                priv;
   logic [NR-1:0][PMP_LEN-1:0]      conf_addr;
   riscv::pmpcfg_t [NR-1:0]         conf;
   logic                            resp_valid_o;
   logic                            resp_ready;
   logic                            resp_allow_o;
   logic                            resp_hit_o;
   logic [IW-1:0]                   resp_entry_o;

   // Behavioural view of the PMP configuration.
   longint unsigned m_addr [NR];
   bit [1:0]        m_amode [NR];
   bit [2:0]        m_perm [NR];
   bit              m_lock [NR];

   // Scoreboard state shared by the driver and the monitor.
   model_t  exp_r;
   int      exp_lat;
   time     acc_time;
   time     prev_acc_time;
   bit      pending;
   bit      got;
   model_t  held;

   int n_checks;
   int n_fail;

   pmp_seq_check #(
      .PLEN       (PLEN),
      .PMP_LEN    (PMP_LEN),
      .NR_ENTRIES (NR)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .flush_i       (flush),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready_o),
      .addr_i        (addr),
      .access_type_i (access),
      .priv_lvl_i    (priv),
      .conf_addr_i   (conf_addr),
      .conf_i        (conf),
      .resp_valid_o  (resp_valid_o),
      .resp_ready_i  (resp_ready),
      .resp_allow_o  (resp_allow_o),
      .resp_hit_o    (resp_hit_o),
      .resp_entry_o  (resp_entry_o)
   );

   initial clk = 1'b0;
   always #(PERIOD / 2) clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Region membership from the address arithmetic of each mode.
   function automatic bit entry_matches(input int i, input longint unsigned a);
      longint unsigned lo, hi, size, base;
      int t;
      case (m_amode[i])
         2'd1: begin
            lo = (i == 0) ? 64'd0 : m_addr[i-1] * 4;
            hi = m_addr[i] * 4;
            return (a >= lo) && (a < hi);
         end
         2'd2: return (a / 4) == m_addr[i];
         2'd3: begin
            t = 0;
            while (t < PMP_LEN && m_addr[i][t]) t++;
            size = 64'd1 << (t + 3);
            base = (m_addr[i] * 4) & ~(size - 1);
            return (a >= base) && ((a - base) < size);
         end
         default: return 1'b0;
      endcase
   endfunction

   function automatic model_t model(input logic [PLEN-1:0] a_in, input logic [2:0] acc,
                                    input logic [1:0] pv);
      model_t r;
      longint unsigned a;
      a = 64'(a_in);
      r = '0;
      r.allow = (pv == PM);
      for (int i = 0; i < NR; i++) begin
         if (entry_matches(i, a)) begin
            r.hit   = 1'b1;
            r.entry = IW'(i);
            r.allow = ((pv == PM) && !m_lock[i]) || ((acc & m_perm[i]) == acc);
            return r;
         end
      end
      return r;
   endfunction

   task automatic clear_cfg();
      for (int i = 0; i < NR; i++) begin
         m_addr[i]  = 0;
         m_amode[i] = 2'd0;
         m_perm[i]  = 3'b000;
         m_lock[i]  = 1'b0;
      end
   endtask

   task automatic apply_cfg();
      for (int i = 0; i < NR; i++) begin
         conf_addr[i]          = PMP_LEN'(m_addr[i]);
         conf[i].locked        = m_lock[i];
         conf[i].addr_mode     = riscv::pmp_addr_mode_t'(m_amode[i]);
         conf[i].access_type   = m_perm[i];
      end
   endtask

   // Pin the model itself against a hand-computed result.
   task automatic pin(input string name, input logic [PLEN-1:0] a, input logic [2:0] acc,
                      input logic [1:0] pv, input bit h, input int en, input bit al);
      model_t e, w;
      e = model(a, acc, pv);
      w.hit   = h;
      w.entry = IW'(en);
      w.allow = al;
      check(name, 64'(e), 64'(w));
   endtask

   // One request: accept, then optional flush mid-scan, back-pressure, or flush in RESP.
   task automatic run_req(input logic [PLEN-1:0] a, input logic [2:0] acc, input logic [1:0] pv,
                          input int hold, input int flush_after, input bit flush_resp);
      model_t e;
      int w;
      e = model(a, acc, pv);
      @(negedge clk);
      w = 0;
      while (!req_ready_o && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready_o) begin
         check("req_ready_timeout", 64'(req_ready_o), 64'd1);
         return;
      end
      addr       = a;
      access     = riscv::pmp_access_t'(acc);
      priv       = riscv::priv_lvl_t'(pv);
      req_valid  = 1'b1;
      resp_ready = (hold == 0) && !flush_resp;
      exp_r      = e;
      exp_lat    = e.hit ? int'(e.entry) + 2 : NR + 1;
      @(posedge clk);
      prev_acc_time = acc_time;
      acc_time      = $time;
      pending       = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      if (flush_after > 0) begin
         repeat (flush_after - 1) @(negedge clk);
         flush = 1'b1;
         @(posedge clk);
         pending = 1'b0;
         @(negedge clk);
         flush      = 1'b0;
         resp_ready = 1'b1;
         return;
      end
      w = 0;
      while (!resp_valid_o && w < NR + 4) begin
         @(negedge clk);
         w++;
      end
      if (!resp_valid_o) begin
         check("resp_valid_timeout", 64'(resp_valid_o), 64'd1);
         pending    = 1'b0;
         resp_ready = 1'b1;
         return;
      end
      if (flush_resp) begin
         repeat (2) @(negedge clk);
         flush = 1'b1;
         @(posedge clk);
         pending = 1'b0;
         @(negedge clk);
         flush = 1'b0;
         check("flush_resp_dropped", 64'(resp_valid_o), 64'd0);
         resp_ready = 1'b1;
         return;
      end
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         resp_ready = 1'b1;
      end
      @(posedge clk);
      pending = 1'b0;
   endtask

   // Compare process: checks latency, result, stability and readiness each cycle.
   always @(negedge clk) begin
      if (!rst_ni) begin
         got = 1'b0;
      end else if (!pending) begin
         got = 1'b0;
         check("idle_valid_low", 64'(resp_valid_o), 64'd0);
         check("idle_ready_high", 64'(req_ready_o), 64'd1);
      end else if (!got) begin
         check("busy_ready_low", 64'(req_ready_o), 64'd0);
         if (resp_valid_o) begin
            check("latency_edges", 64'(int'(($time - acc_time) / PERIOD)), 64'(exp_lat - 1));
            check("resp_hit", 64'(resp_hit_o), 64'(exp_r.hit));
            check("resp_entry", 64'(resp_entry_o), 64'(exp_r.entry));
            check("resp_allow", 64'(resp_allow_o), 64'(exp_r.allow));
            held.hit   = resp_hit_o;
            held.entry = resp_entry_o;
            held.allow = resp_allow_o;
            got        = 1'b1;
         end
      end else begin
         check("hold_valid", 64'(resp_valid_o), 64'd1);
         check("hold_ready_low", 64'(req_ready_o), 64'd0);
         check("hold_result", 64'({resp_hit_o, resp_entry_o, resp_allow_o}), 64'(held));
      end
   end

   initial begin
      int prev_lat;
      int sel;
      int j;
      int t;
      longint unsigned base_w;
      logic [PLEN-1:0] ra;
      logic [1:0] rp;

      n_checks   = 0;
      n_fail     = 0;
      pending    = 1'b0;
      got        = 1'b0;
      acc_time   = 0;
      prev_acc_time = 0;
      rst_ni     = 1'b0;
      flush      = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      addr       = '0;
      access     = riscv::ACCESS_READ;
      priv       = riscv::PRIV_LVL_U;
      clear_cfg();
      apply_cfg();

      // Reset values.
      #3;
      check("rst_ready", 64'(req_ready_o), 64'd1);
      check("rst_valid", 64'(resp_valid_o), 64'd0);
      check("rst_allow", 64'(resp_allow_o), 64'd0);
      check("rst_hit", 64'(resp_hit_o), 64'd0);
      check("rst_entry", 64'(resp_entry_o), 64'd0);
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;

      // TOR entry 0 up to 0x1000 with read permission only.
      clear_cfg();
      m_addr[0] = 64'h400; m_amode[0] = 2'd1; m_perm[0] = RD;
      apply_cfg();
      pin("pin_tor_read", 56'h800, RD, PS, 1'b1, 0, 1'b1);
      pin("pin_tor_write", 56'h800, WR, PS, 1'b1, 0, 1'b0);
      pin("pin_tor_top_excl", 56'h1000, RD, PU, 1'b0, 0, 1'b0);
      run_req(56'h800, RD, PS, 0, 0, 1'b0);
      run_req(56'h800, WR, PS, 0, 0, 1'b0);
      run_req(56'h1000, RD, PU, 0, 0, 1'b0);
      run_req(56'hFFF, RD, PU, 0, 0, 1'b0);

      // NAPOT priority: entry 5 RWX wins over entry 9 with no permissions.
      clear_cfg();
      m_addr[5] = 64'h83FF; m_amode[5] = 2'd3; m_perm[5] = 3'b111;
      m_addr[9] = 64'h83FF; m_amode[9] = 2'd3; m_perm[9] = 3'b000;
      apply_cfg();
      pin("pin_napot_exec", 56'h20ABC, EX, PU, 1'b1, 5, 1'b1);
      pin("pin_napot_above", 56'h22000, RD, PU, 1'b0, 0, 1'b0);
      pin("pin_napot_below", 56'h1FFFF, RD, PM, 1'b0, 0, 1'b1);
      run_req(56'h20ABC, EX, PU, 0, 0, 1'b0);

      // Back-to-back with resp_ready held high: one request per latency+1.
      run_req(56'h20000, RD, PS, 0, 0, 1'b0);
      prev_lat = exp_lat;
      run_req(56'h22000, RD, PU, 0, 0, 1'b0);
      check("b2b_period_hit", 64'(int'((acc_time - prev_acc_time) / PERIOD)), 64'(prev_lat + 1));
      prev_lat = exp_lat;
      run_req(56'h21FFF, WR, PU, 0, 0, 1'b0);
      check("b2b_period_miss", 64'(int'((acc_time - prev_acc_time) / PERIOD)), 64'(prev_lat + 1));

      // Full miss with all entries OFF.
      clear_cfg();
      apply_cfg();
      pin("pin_miss_m", 56'h0, RD, PM, 1'b0, 0, 1'b1);
      pin("pin_miss_u", 56'h0, RD, PU, 1'b0, 0, 1'b0);
      run_req(56'h0, RD, PM, 0, 0, 1'b0);
      run_req(56'h0, RD, PU, 0, 0, 1'b0);

      // Flush mid-scan: no response, then a normal request.
      run_req(56'h0, RD, PM, 0, 3, 1'b0);
      check("flush_scan_idle", 64'(req_ready_o), 64'd1);
      repeat (20) @(negedge clk);
      run_req(56'h0, RD, PM, 0, 0, 1'b0);

      // Flush in IDLE beats a simultaneous request.
      @(negedge clk);
      addr      = 56'h0;
      req_valid = 1'b1;
      flush     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      flush     = 1'b0;
      check("flush_idle_not_taken", 64'(req_ready_o), 64'd1);
      repeat (4) @(negedge clk);

      // Lock: NA4 at 0x400, R only.
      clear_cfg();
      m_addr[2] = 64'h100; m_amode[2] = 2'd2; m_perm[2] = RD; m_lock[2] = 1'b1;
      apply_cfg();
      pin("pin_lock_m_write", 56'h400, WR, PM, 1'b1, 2, 1'b0);
      run_req(56'h400, WR, PM, 0, 0, 1'b0);
      run_req(56'h404, WR, PM, 0, 0, 1'b0);

      // Back-pressure for 5 cycles, then flush dropping a pending response.
      run_req(56'h400, RD, PU, 5, 0, 1'b0);
      run_req(56'h400, RD, PS, 0, 0, 1'b1);

      m_lock[2] = 1'b0;
      apply_cfg();
      pin("pin_unlock_m_write", 56'h400, WR, PM, 1'b1, 2, 1'b1);
      run_req(56'h400, WR, PM, 0, 0, 1'b0);

      // Asynchronous reset during a scan returns outputs to reset values.
      clear_cfg();
      apply_cfg();
      @(negedge clk);
      addr      = 56'h0;
      access    = riscv::ACCESS_READ;
      priv      = riscv::PRIV_LVL_U;
      req_valid = 1'b1;
      exp_r     = model(56'h0, RD, PU);
      exp_lat   = NR + 1;
      @(posedge clk);
      acc_time = $time;
      pending  = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst_ni  = 1'b0;
      pending = 1'b0;
      #1;
      check("arst_valid", 64'(resp_valid_o), 64'd0);
      check("arst_ready", 64'(req_ready_o), 64'd1);
      check("arst_hit", 64'(resp_hit_o), 64'd0);
      check("arst_allow", 64'(resp_allow_o), 64'd0);
      check("arst_entry", 64'(resp_entry_o), 64'd0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Randomized configurations and requests.
      for (int n = 0; n < 48; n++) begin
         if (n % 8 == 0) begin
            for (int i = 0; i < NR; i++) begin
               m_amode[i] = 2'($urandom_range(0, 3));
               m_perm[i]  = 3'($urandom_range(0, 7));
               m_lock[i]  = 1'($urandom_range(0, 1));
               if (m_amode[i] == 2'd3) begin
                  t = $urandom_range(0, 8);
                  base_w = 64'($urandom_range(0, 16'h3FFF));
                  m_addr[i] = (base_w & ~((64'd1 << (t + 1)) - 1)) | ((64'd1 << t) - 1);
               end else begin
                  m_addr[i] = 64'($urandom_range(0, 16'h3FFF));
               end
            end
            apply_cfg();
         end
         sel = $urandom_range(0, 3);
         j   = $urandom_range(0, NR - 1);
         case (sel)
            0:       ra = 56'($urandom_range(0, 16'hFFFF));
            1:       ra = 56'(m_addr[j] << 2);
            2:       ra = 56'(m_addr[j] << 2) - 56'd1;
            default: ra = 56'(m_addr[j] << 2) + 56'd3;
         endcase
         case ($urandom_range(0, 2))
            0:       rp = PU;
            1:       rp = PS;
            default: rp = PM;
         endcase
         run_req(ra, 3'b001 << $urandom_range(0, 2), rp, $urandom_range(0, 2), 0, 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
